// File: rtl/cam_pkg.sv
// Shared sizes and types for the 32-entry CAM storage/search stage.
package cam_pkg;

  localparam int unsigned CAM_DATA_WIDTH = 32;
  localparam int unsigned CAM_ADDR_WIDTH = 5;
  localparam int unsigned CAM_DEPTH      = 32;

  typedef logic [CAM_DATA_WIDTH-1:0] cam_data_t;
  typedef logic [CAM_ADDR_WIDTH-1:0] cam_index_t;
  typedef logic [CAM_DEPTH-1:0]      cam_valid_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: reports whether any request bit is set and the
// index of the lowest set bit (0 when none is set).
module cam_prio_enc #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [DEPTH-1:0]      req_i,
  output logic                  any_o,
  output logic [ADDR_WIDTH-1:0] index_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any_o   = |req_i;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        index_o = ADDR_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/cam_array.sv
// CAM storage and search stage: indexed write/invalidate, associative search with
// a registered lowest-index hit, plus flat data/valid outputs for the downstream mux.
module cam_array
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = CAM_DEPTH
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        write_i,
  input  logic [ADDR_WIDTH-1:0]       write_index_i,
  input  logic [DATA_WIDTH-1:0]       write_data_i,
  input  logic                        invalidate_i,
  input  logic [ADDR_WIDTH-1:0]       invalidate_index_i,
  input  logic                        search_i,
  input  logic [DATA_WIDTH-1:0]       search_data_i,
  output logic                        search_valid_o,
  output logic                        search_found_o,
  output logic [ADDR_WIDTH-1:0]       search_index_o,
  output logic [DEPTH*DATA_WIDTH-1:0] all_data_o,
  output logic [DEPTH-1:0]            read_valid_o,
  output logic                        full_o,
  output logic [ADDR_WIDTH-1:0]       free_index_o
);

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic                  r_search_valid;
  logic                  r_search_found;
  logic [ADDR_WIDTH-1:0] r_search_index;

  logic [DEPTH-1:0]      w_hit;
  logic                  w_hit_any;
  logic [ADDR_WIDTH-1:0] w_hit_index;
  logic                  w_free_any;

  // Entry storage; the write is applied after the invalidate so it wins on the same index.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (invalidate_i) begin
        r_valid[invalidate_index_i] <= 1'b0;
      end
      if (write_i) begin
        r_valid[write_index_i] <= 1'b1;
        r_data[write_index_i]  <= write_data_i;
      end
    end
  end

  // Compare the key against pre-edge contents; invalid entries never match.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit[k] = r_valid[k] && (r_data[k] == search_data_i);
    end
  end

  cam_prio_enc #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hit_enc (
    .req_i   (w_hit),
    .any_o   (w_hit_any),
    .index_o (w_hit_index)
  );

  cam_prio_enc #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_free_enc (
    .req_i   (~r_valid),
    .any_o   (w_free_any),
    .index_o (free_index_o)
  );

  // Search result register: pulse per request, found/index held until the next search.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_search_valid <= 1'b0;
      r_search_found <= 1'b0;
      r_search_index <= '0;
    end else begin
      r_search_valid <= search_i;
      if (search_i) begin
        r_search_found <= w_hit_any;
        r_search_index <= w_hit_index;
      end
    end
  end

  // Flatten storage onto the bus consumed by the downstream mux.
  always_comb begin
    all_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      all_data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_data[k];
    end
  end

  assign read_valid_o   = r_valid;
  assign full_o         = ~w_free_any;
  assign search_valid_o = r_search_valid;
  assign search_found_o = r_search_found;
  assign search_index_o = r_search_index;

endmodule

// File: tb/tb_cam_array.sv
// Self-checking bench for cam_array: directed table, fill/full corner, randomized
// traffic against an array-based reference model, and reset during a search.
module tb_cam_array;
  import cam_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic                 write_i;
  cam_index_t           write_index_i;
  cam_data_t            write_data_i;
  logic                 invalidate_i;
  cam_index_t           invalidate_index_i;
  logic                 search_i;
  cam_data_t            search_data_i;
  logic                 search_valid_o;
  logic                 search_found_o;
  cam_index_t           search_index_o;
  logic [CAM_DEPTH*CAM_DATA_WIDTH-1:0] all_data_o;
  cam_valid_t           read_valid_o;
  logic                 full_o;
  cam_index_t           free_index_o;

  cam_array dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .write_i            (write_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .invalidate_i       (invalidate_i),
    .invalidate_index_i (invalidate_index_i),
    .search_i           (search_i),
    .search_data_i      (search_data_i),
    .search_valid_o     (search_valid_o),
    .search_found_o     (search_found_o),
    .search_index_o     (search_index_o),
    .all_data_o         (all_data_o),
    .read_valid_o       (read_valid_o),
    .full_o             (full_o),
    .free_index_o       (free_index_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  cam_data_t  m_data [CAM_DEPTH];
  logic       m_valid [CAM_DEPTH];
  logic       m_sv;
  logic       m_found;
  int         m_index;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CAM_DEPTH; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_sv    = 1'b0;
    m_found = 1'b0;
    m_index = 0;
  endtask

  task automatic idle_inputs();
    write_i            = 1'b0;
    write_index_i      = '0;
    write_data_i       = '0;
    invalidate_i       = 1'b0;
    invalidate_index_i = '0;
    search_i           = 1'b0;
    search_data_i      = '0;
  endtask

  // Compare every DUT output against the model.
  task automatic check_all(input string tag);
    int   free_idx;
    int   bad;
    logic full;
    cam_valid_t vexp;
    full     = 1'b1;
    free_idx = 0;
    for (int k = CAM_DEPTH - 1; k >= 0; k--) begin
      vexp[k] = m_valid[k];
      if (!m_valid[k]) begin
        full     = 1'b0;
        free_idx = k;
      end
    end
    bad = 0;
    for (int k = 0; k < CAM_DEPTH; k++) begin
      if (all_data_o[k*CAM_DATA_WIDTH +: CAM_DATA_WIDTH] !== m_data[k]) bad++;
    end
    check({tag, ".search_valid"}, longint'(search_valid_o), longint'(m_sv));
    check({tag, ".found"}, longint'(search_found_o), longint'(m_found));
    check({tag, ".index"}, longint'(search_index_o), longint'(m_index));
    check({tag, ".read_valid"}, longint'(read_valid_o), longint'(vexp));
    check({tag, ".full"}, longint'(full_o), longint'(full));
    check({tag, ".free_index"}, longint'(free_index_o), longint'(free_idx));
    check({tag, ".bad_data_entries"}, longint'(bad), 0);
  endtask

  // One cycle of stimulus; model applies the spec rules, then all outputs compared.
  task automatic apply(input logic wr, input int wi, input cam_data_t wd,
                       input logic inv, input int ii, input logic s, input cam_data_t sk,
                       input string tag);
    write_i            = wr;
    write_index_i      = cam_index_t'(wi);
    write_data_i       = wd;
    invalidate_i       = inv;
    invalidate_index_i = cam_index_t'(ii);
    search_i           = s;
    search_data_i      = sk;
    if (s) begin
      m_found = 1'b0;
      m_index = 0;
      for (int k = 0; k < CAM_DEPTH; k++) begin
        if (!m_found && m_valid[k] && m_data[k] == sk) begin
          m_found = 1'b1;
          m_index = k;
        end
      end
    end
    m_sv = s;
    @(posedge clk_i);
    #1;
    if (inv) m_valid[ii] = 1'b0;
    if (wr) begin
      m_valid[wi] = 1'b1;
      m_data[wi]  = wd;
    end
    idle_inputs();
    check_all(tag);
  endtask

  typedef struct {
    logic      wr;
    int        wi;
    cam_data_t wd;
    logic      inv;
    int        ii;
    logic      s;
    cam_data_t sk;
    logic      exp_sv;
    logic      exp_found;
    int        exp_index;
    cam_valid_t exp_rv;
    int        exp_free;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Directed vectors with hand-derived expectations
    tbl[0]  = '{1, 0, 32'h48371832, 0, 0, 0, 32'h0,        0, 0, 0, 32'h1,   1};
    tbl[1]  = '{1, 1, 32'h49385029, 0, 0, 0, 32'h0,        0, 0, 0, 32'h3,   2};
    tbl[2]  = '{0, 0, 32'h0,        0, 0, 1, 32'h49385029, 1, 1, 1, 32'h3,   2};
    tbl[3]  = '{1, 4, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 1, 1, 32'h13,  2};
    tbl[4]  = '{1, 9, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 1, 1, 32'h213, 2};
    tbl[5]  = '{0, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 1, 4, 32'h213, 2};
    tbl[6]  = '{0, 0, 32'h0,        1, 4, 0, 32'h0,        0, 1, 4, 32'h203, 2};
    tbl[7]  = '{0, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 1, 9, 32'h203, 2};
    tbl[8]  = '{0, 0, 32'h0,        1, 9, 0, 32'h0,        0, 1, 9, 32'h3,   2};
    tbl[9]  = '{0, 0, 32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h3,   2};
    tbl[10] = '{1, 7, 32'h17384958, 1, 7, 1, 32'h17384958, 1, 0, 0, 32'h83,  2};
    tbl[11] = '{0, 0, 32'h0,        0, 0, 1, 32'h17384958, 1, 1, 7, 32'h83,  2};

    idle_inputs();
    model_reset();
    reset_n_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1;
    end
    check_all("reset");

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].wr, tbl[i].wi, tbl[i].wd, tbl[i].inv, tbl[i].ii, tbl[i].s, tbl[i].sk,
            $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.sv", i), longint'(search_valid_o), longint'(tbl[i].exp_sv));
      check($sformatf("tbl%0d.found", i), longint'(search_found_o), longint'(tbl[i].exp_found));
      check($sformatf("tbl%0d.index", i), longint'(search_index_o), longint'(tbl[i].exp_index));
      check($sformatf("tbl%0d.rv", i), longint'(read_valid_o), longint'(tbl[i].exp_rv));
      check($sformatf("tbl%0d.free", i), longint'(free_index_o), longint'(tbl[i].exp_free));
    end

    // Fill every entry, then free the top one
    for (int k = 0; k < CAM_DEPTH; k++) begin
      apply(1, k, cam_data_t'(32'h100 + k), 0, 0, 0, '0, "fill");
    end
    check("fill.full", longint'(full_o), 1);
    check("fill.free", longint'(free_index_o), 0);
    apply(0, 0, '0, 1, 31, 0, '0, "inv31");
    check("inv31.full", longint'(full_o), 0);
    check("inv31.free", longint'(free_index_o), 31);

    // Randomized traffic; a small value space forces duplicates and multi-hits
    for (int n = 0; n < 400; n++) begin
      apply(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            cam_data_t'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), cam_data_t'($urandom_range(0, 7)), "rand");
    end

    // Search sampled together with reset: reset wins and the pulse is suppressed
    write_i       = 1'b1;
    write_index_i = 5'd3;
    write_data_i  = 32'hA5A5A5A5;
    @(posedge clk_i);
    #1;
    idle_inputs();
    search_i      = 1'b1;
    search_data_i = 32'hA5A5A5A5;
    reset_n_i     = 1'b0;
    @(posedge clk_i);
    #1;
    idle_inputs();
    reset_n_i = 1'b1;
    model_reset();
    check_all("rst_search");
    @(posedge clk_i);
    #1;
    check_all("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
